dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data word width; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 256, number of words; SHALL be a power of two >= 2.
REQ-003 Parameter LATENCY, default 2, wait states between accept and response; legal range 0..7.
REQ-004 Derived ADDR_W = $clog2(DEPTH) + $clog2(DATA_W/8); byte addressing.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  block can accept a request.
REQ-009 req_we  in  1  1 = store, 0 = load.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  DATA_W  store data.
REQ-012 req_wstrb  in  DATA_W/8  byte-lane write enables; lane i maps to bits [8i+7:8i].
REQ-013 rsp_valid  out  1  one-cycle response pulse.
REQ-014 rsp_rdata  out  DATA_W  load data; valid only while rsp_valid is high.
REQ-015 rsp_err  out  1  request faulted; valid only while rsp_valid is high.

Function
REQ-016 FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 Accept occurs on a rising edge where req_valid and req_ready are both 1; addr, we, wdata and wstrb SHALL be registered at that edge, so later input changes have no effect.
REQ-018 Accept transitions: IDLE->WAIT with a countdown loaded to LATENCY-1 when LATENCY>0, or IDLE->RESP when LATENCY=0.
REQ-019 WAIT->RESP when the countdown reaches 0; otherwise the countdown decrements.
REQ-020 RESP lasts exactly one cycle, then RESP->IDLE.
REQ-021 rsp_valid SHALL be 1 exactly in RESP, i.e. LATENCY+1 cycles after the accepting edge.
REQ-022 Peak throughput SHALL be one request per LATENCY+2 cycles.
REQ-023 A request is faulted when the address is misaligned (low $clog2(DATA_W/8) bits nonzero); rsp_err=1 for a faulted request.
REQ-024 Faulted requests SHALL NOT modify memory, and rsp_rdata SHALL be 0 for them.
REQ-025 A non-faulted store SHALL write only the strobed byte lanes, on the edge entering RESP.
REQ-026 A non-faulted store SHALL drive rsp_err=0 and rsp_rdata=0.
REQ-027 A store with req_wstrb=0 SHALL complete normally with no memory change.
REQ-028 A non-faulted load SHALL return the word at addr>>$clog2(DATA_W/8), read on the edge entering RESP, so it reflects all previously completed stores; rsp_err=0.
REQ-029 The address wraps modulo DEPTH words; no out-of-range fault exists.
REQ-030 Outside RESP, rsp_rdata=0 and rsp_err=0.
REQ-031 Memory contents are not initialised by the block; bench reads SHALL be preceded by writes.

Reset
REQ-032 While rst=1, immediately and independent of clk: state=IDLE, countdown=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-033 Memory array contents SHALL be unaffected by rst.
REQ-034 Reset asserted in WAIT or RESP SHALL abort the pending request, with no rsp_valid pulse for it.
REQ-035 A store aborted by reset before its commit edge SHALL leave memory unchanged.
REQ-036 The first accept is possible on the first rising edge after rst deasserts.

Verification (DATA_W=32, DEPTH=32, LATENCY=2 unless stated)
REQ-037 Store 0x0000000F to addr 0x0, wstrb=0xF, accepted at edge E -> rsp_valid=1 exactly in the cycle after edge E+2 with rsp_err=0; req_ready=0 from E until rsp_valid falls.
REQ-038 Store 0xABCD1234 (wstrb=0xF) to addr 0x4, then store 0x000000EE with wstrb=0x1 to addr 0x4, then load addr 0x4 -> rsp_rdata=0xABCD12EE.
REQ-039 Load addr 0x6 -> rsp_err=1, rsp_rdata=0; a subsequent load of addr 0x4 returns the unchanged word.
REQ-040 Store 0x55 to addr 0x80 (word 32 wraps to word 0) -> a load of addr 0x0 returns 0x00000055.
REQ-041 Store 0x11111111 to addr 0x8, then store 0x22222222 to addr 0x8 with rst asserted one cycle after accept -> no rsp_valid pulse, req_ready=1 immediately, and a load of addr 0x8 returns 0x11111111.
REQ-042 LATENCY=0, back-to-back req_valid held high -> accepts every 2 cycles, and each rsp_valid pulse occurs in the cycle after its accept.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Single-port data memory with byte strobes and misalignment faults behind a valid/ready request port.
// Latency: response LATENCY+1 cycles after accept; req_ready is low while busy, giving one request per LATENCY+2 cycles.
module dmem_ctrl #(
    parameter  int DATA_W  = 32,
    parameter  int DEPTH   = 256,
    parameter  int LATENCY = 2,
    localparam int ADDR_W  = $clog2(DEPTH) + $clog2(DATA_W/8)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);
    localparam int LANES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(LANES);
    localparam int WORD_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
    localparam logic [2:0] CNT_INIT = 3'(LATENCY > 0 ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state;
    logic [2:0]          cnt;
    logic [WORD_W-1:0]   a_word;
    logic                a_err;
    logic                a_we;
    logic [DATA_W-1:0]   a_wdata;
    logic [LANES-1:0]    a_wstrb;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                commit;
    logic [WORD_W-1:0]   c_word;
    logic                c_err;
    logic                c_we;
    logic [DATA_W-1:0]   c_wdata;
    logic [LANES-1:0]    c_wstrb;

    // With zero wait states the commit happens on the accepting edge, so the
    // committed request comes straight from the port rather than the capture regs.
    always_comb begin
        accept = (state == IDLE) && req_valid;
        if (state == IDLE) begin
            c_word  = WORD_W'(req_addr >> OFF_W);
            c_err   = (req_addr & OFF_MASK) != '0;
            c_we    = req_we;
            c_wdata = req_wdata;
            c_wstrb = req_wstrb;
        end else begin
            c_word  = a_word;
            c_err   = a_err;
            c_we    = a_we;
            c_wdata = a_wdata;
            c_wstrb = a_wstrb;
        end
        commit = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 3'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            a_word    <= '0;
            a_err     <= 1'b0;
            a_we      <= 1'b0;
            a_wdata   <= '0;
            a_wstrb   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (accept) begin
                a_word  <= c_word;
                a_err   <= c_err;
                a_we    <= c_we;
                a_wdata <= c_wdata;
                a_wstrb <= c_wstrb;
            end
            if (commit) begin
                state     <= RESP;
                req_ready <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_err   <= c_err;
                rsp_rdata <= (!c_we && !c_err) ? mem[c_word] : '0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        state     <= WAIT;
                        cnt       <= CNT_INIT;
                        req_ready <= 1'b0;
                    end
                    WAIT: cnt <= cnt - 3'd1;
                    RESP: begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                    default: begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Array is deliberately outside the reset domain; reset only aborts pending stores.
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err && !rst) begin
            for (int i = 0; i < LANES; i++) begin
                if (c_wstrb[i])
                    mem[c_word][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
    localparam int ADDR_W = 7;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        r0_valid, r0_ready, r0_we;
    logic [6:0]  r0_addr;
    logic [31:0] r0_wdata;
    logic [3:0]  r0_wstrb;
    logic        s0_valid, s0_err;
    logic [31:0] s0_rdata;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];

    dmem_ctrl #(.DATA_W(32), .DEPTH(32), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_ctrl #(.DATA_W(32), .DEPTH(32), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(r0_valid), .req_ready(r0_ready), .req_we(r0_we),
        .req_addr(r0_addr), .req_wdata(r0_wdata), .req_wstrb(r0_wstrb),
        .rsp_valid(s0_valid), .rsp_rdata(s0_rdata), .rsp_err(s0_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expected response whenever a DUT presents one.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid) begin
            if (q2.size() == 0) begin
                tests++; fails++;
                $display("FAIL lat2_unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
                e = q2.pop_front();
                chk("lat2_rdata", rsp_rdata, e.rdata);
                chk("lat2_err", 32'(rsp_err), 32'(e.err));
                chk("lat2_rsp_cycle", cyc, e.cyc);
                chk("lat2_ready_in_resp", 32'(req_ready), 32'd0);
            end
        end else begin
            chk("lat2_idle_rdata", rsp_rdata, 32'd0);
            chk("lat2_idle_err", 32'(rsp_err), 32'd0);
        end
        if (s0_valid) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL lat0_unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
                e = q0.pop_front();
                chk("lat0_rdata", s0_rdata, e.rdata);
                chk("lat0_err", 32'(s0_err), 32'(e.err));
                chk("lat0_rsp_cycle", cyc, e.cyc);
            end
        end else begin
            chk("lat0_idle_rdata", s0_rdata, 32'd0);
            chk("lat0_idle_err", 32'(s0_err), 32'd0);
        end
    end

    // Entered and left at a falling edge; accept happens on the next rising edge.
    task automatic issue(input logic we, input int addr, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] er, input logic ee,
                         input bit expect_rsp);
        int n = 0;
        int acc;
        exp_t e;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("lat2_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = ADDR_W'(addr);
        req_wdata = wd;
        req_wstrb = ws;
        acc = cyc + 1;
        if (expect_rsp) begin
            e.rdata = er; e.err = ee; e.cyc = acc + 2;
            q2.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ADDR_W'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        chk("lat2_ready_low_after_accept", 32'(req_ready), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        v_we [5]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int          v_addr [5] = '{0, 4, 0, 4, 2};
        logic [31:0] v_wd [5]   = '{32'hA0, 32'hB1, 32'h0, 32'h0, 32'h0};
        logic [31:0] v_er [5]   = '{32'h0, 32'h0, 32'hA0, 32'hB1, 32'h0};
        logic        v_ee [5]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int prev = 0;
        int acc;
        int n;
        exp_t e;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        r0_valid = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0; r0_wstrb = '0;
        #1;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue(1'b1, 'h00, 32'h0000000F, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 'h04, 32'hABCD1234, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 'h04, 32'h000000EE, 4'h1, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 'h04, 32'h0,        4'h0, 32'hABCD12EE, 1'b0, 1'b1);
        issue(1'b0, 'h06, 32'h0,        4'h0, 32'h0, 1'b1, 1'b1);
        issue(1'b0, 'h04, 32'h0,        4'h0, 32'hABCD12EE, 1'b0, 1'b1);
        issue(1'b1, 'h04, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 'h05, 32'h00000000, 4'hF, 32'h0, 1'b1, 1'b1);
        issue(1'b0, 'h04, 32'h0,        4'h0, 32'hABCD12EE, 1'b0, 1'b1);
        issue(1'b0, 'h00, 32'h0,        4'h0, 32'h0000000F, 1'b0, 1'b1);
        issue(1'b1, 'h80, 32'h00000055, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 'h00, 32'h0,        4'h0, 32'h00000055, 1'b0, 1'b1);
        issue(1'b1, 'h7C, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 'hFC, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 1'b1);

        issue(1'b1, 'h08, 32'h11111111, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 'h08, 32'h22222222, 4'hF, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 'h08, 32'h0, 4'h0, 32'h11111111, 1'b0, 1'b1);
        issue(1'b0, 'h00, 32'h0, 4'h0, 32'h00000055, 1'b0, 1'b1);

        // Zero-latency instance with req_valid held high across requests.
        for (int i = 0; i < 5; i++) begin
            r0_valid = 1'b1;
            r0_we    = v_we[i];
            r0_addr  = ADDR_W'(v_addr[i]);
            r0_wdata = v_wd[i];
            r0_wstrb = 4'hF;
            n = 0;
            while (!r0_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("lat0_ready_timeout", 32'(r0_ready), 32'd1);
            acc = cyc + 1;
            e.rdata = v_er[i]; e.err = v_ee[i]; e.cyc = acc;
            q0.push_back(e);
            if (i > 0) chk("lat0_accept_spacing", acc - prev, 32'd2);
            prev = acc;
            @(negedge clk);
        end
        r0_valid = 1'b0;

        repeat (10) @(negedge clk);
        chk("lat2_queue_drained", q2.size(), 32'd0);
        chk("lat0_queue_drained", q0.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
